// File: rtl/reg_status_file_if.sv
// Dispatch, CDB and read-port bundle for the rename-status register file.
// master drives requests and CDB; slave is the register file.
interface reg_status_file_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2,
   parameter int unsigned TAGW  = 4
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [NREAD*AW-1:0]   rs_in;
   logic [NREAD*XLEN-1:0] rd_val_out;
   logic [NREAD-1:0]      rd_busy_out;
   logic [NREAD*TAGW-1:0] rd_tag_out;
   logic                  disp_valid_in;
   logic [AW-1:0]         disp_rd_in;
   logic [TAGW-1:0]       disp_tag_in;
   logic                  cdb_valid_in;
   logic [TAGW-1:0]       cdb_tag_in;
   logic [XLEN-1:0]       cdb_data_in;
   logic                  flush_in;

   modport master (
      output rs_in, disp_valid_in, disp_rd_in, disp_tag_in,
             cdb_valid_in, cdb_tag_in, cdb_data_in, flush_in,
      input  rd_val_out, rd_busy_out, rd_tag_out
   );

   modport slave (
      input  rs_in, disp_valid_in, disp_rd_in, disp_tag_in,
             cdb_valid_in, cdb_tag_in, cdb_data_in, flush_in,
      output rd_val_out, rd_busy_out, rd_tag_out
   );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy/tag rename status,
// CDB writeback and combinational read ports with same-cycle CDB bypass.
module reg_status_file #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2,
   parameter int unsigned TAGW  = 4
) (
   input logic              clk_in,
   input logic              rst_in,
   reg_status_file_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] val_q  [NREGS];
   logic [XLEN-1:0] val_d  [NREGS];
   logic            busy_q [NREGS];
   logic            busy_d [NREGS];
   logic [TAGW-1:0] tag_q  [NREGS];
   logic [TAGW-1:0] tag_d  [NREGS];
   logic [NREGS-1:0] cdb_hit;

   logic [NREAD*XLEN-1:0] rd_val;
   logic [NREAD-1:0]      rd_busy;
   logic [NREAD*TAGW-1:0] rd_tag;

   // Order matters: CDB writes first, a same-cycle dispatch then re-claims
   // the register (newest producer wins), and flush finally clears busy.
   always_comb begin
      cdb_hit = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         val_d[i]  = val_q[i];
         busy_d[i] = busy_q[i];
         tag_d[i]  = tag_q[i];
         if (i == 0) begin
            val_d[i]  = '0;
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
         end else begin
            cdb_hit[i] = bus.cdb_valid_in && busy_q[i] && (tag_q[i] == bus.cdb_tag_in);
            if (cdb_hit[i]) begin
               val_d[i]  = bus.cdb_data_in;
               busy_d[i] = 1'b0;
            end
            if (bus.disp_valid_in && !bus.flush_in && (bus.disp_rd_in == AW'(i))) begin
               busy_d[i] = 1'b1;
               tag_d[i]  = bus.disp_tag_in;
            end
            if (bus.flush_in) begin
               busy_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            val_q[i]  <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   // Reads see only registered state plus the CDB bypass, never dispatch or flush.
   always_comb begin
      rd_val  = '0;
      rd_busy = '0;
      rd_tag  = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         if (busy_q[bus.rs_in[k*AW +: AW]] && bus.cdb_valid_in &&
             (tag_q[bus.rs_in[k*AW +: AW]] == bus.cdb_tag_in)) begin
            rd_val[k*XLEN +: XLEN] = bus.cdb_data_in;
            rd_busy[k]             = 1'b0;
         end else begin
            rd_val[k*XLEN +: XLEN] = val_q[bus.rs_in[k*AW +: AW]];
            rd_busy[k]             = busy_q[bus.rs_in[k*AW +: AW]];
         end
         rd_tag[k*TAGW +: TAGW] = tag_q[bus.rs_in[k*AW +: AW]];
      end
   end

   assign bus.rd_val_out  = rd_val;
   assign bus.rd_busy_out = rd_busy;
   assign bus.rd_tag_out  = rd_tag;
endmodule

// File: tb/tb_reg_status_file.sv
// Directed scoreboard bench for reg_status_file (4 read ports, 32x32, 4-bit tags).
module tb_reg_status_file;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NREAD = 4;
   localparam int unsigned TAGW  = 4;
   localparam int unsigned AW    = 5;

   logic clk_in;
   logic rst_in;

   reg_status_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .TAGW(TAGW)) bus ();

   reg_status_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .TAGW(TAGW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   typedef struct {
      string           nm;
      int              port;
      logic [XLEN-1:0] val;
      logic            busy;
      logic [TAGW-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic expect_rd(input string nm, input int port, input logic [XLEN-1:0] v,
                            input logic b, input logic [TAGW-1:0] t);
      exp_t e;
      e.nm = nm; e.port = port; e.val = v; e.busy = b; e.tag = t;
      sb.push_back(e);
   endtask

   task automatic check_q();
      exp_t e;
      logic [XLEN-1:0] gv;
      logic            gb;
      logic [TAGW-1:0] gt;
      #1;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         gv = bus.rd_val_out[e.port*XLEN +: XLEN];
         gb = bus.rd_busy_out[e.port];
         gt = bus.rd_tag_out[e.port*TAGW +: TAGW];
         vectors++;
         assert ({gv, gb, gt} === {e.val, e.busy, e.tag}) else begin
            miscompares++;
            $error("FAIL %s port%0d: got val=%h busy=%b tag=%h, required val=%h busy=%b tag=%h",
                   e.nm, e.port, gv, gb, gt, e.val, e.busy, e.tag);
         end
      end
   endtask

   task automatic set_rs(input int k, input logic [AW-1:0] a);
      bus.rs_in[k*AW +: AW] = a;
   endtask

   task automatic idle();
      bus.disp_valid_in = 1'b0;
      bus.disp_rd_in    = '0;
      bus.disp_tag_in   = '0;
      bus.cdb_valid_in  = 1'b0;
      bus.cdb_tag_in    = '0;
      bus.cdb_data_in   = '0;
      bus.flush_in      = 1'b0;
   endtask

   task automatic disp(input logic [AW-1:0] rd, input logic [TAGW-1:0] t);
      bus.disp_valid_in = 1'b1;
      bus.disp_rd_in    = rd;
      bus.disp_tag_in   = t;
   endtask

   task automatic cdb(input logic [TAGW-1:0] t, input logic [XLEN-1:0] d);
      bus.cdb_valid_in = 1'b1;
      bus.cdb_tag_in   = t;
      bus.cdb_data_in  = d;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      idle();
   endtask

   initial begin
      rst_in   = 1'b1;
      bus.rs_in = '0;
      idle();
      #2 rst_in = 1'b0;
      set_rs(0, 5); set_rs(1, 0); set_rs(2, 31); set_rs(3, 1);
      for (int k = 0; k < 4; k++) expect_rd("reset", k, '0, 1'b0, '0);
      check_q();
      tick();
      tick();
      rst_in = 1'b1;
      tick();

      // dispatch r5/tag3: invisible in the dispatch cycle, visible next cycle
      disp(5, 3);
      set_rs(0, 5);
      expect_rd("disp_same_cycle", 0, '0, 1'b0, '0);
      check_q();
      tick();
      expect_rd("disp_next", 0, '0, 1'b1, 4'd3);
      check_q();

      // non-matching CDB tag leaves r5 busy
      cdb(7, 32'h0000_1234);
      expect_rd("cdb_miss_same", 0, '0, 1'b1, 4'd3);
      check_q();
      tick();
      expect_rd("cdb_miss_next", 0, '0, 1'b1, 4'd3);
      check_q();

      // matching CDB: bypass on two ports, then stored
      cdb(3, 32'hDEAD_BEEF);
      set_rs(1, 5);
      expect_rd("cdb_bypass_p0", 0, 32'hDEAD_BEEF, 1'b0, 4'd3);
      expect_rd("cdb_bypass_p1", 1, 32'hDEAD_BEEF, 1'b0, 4'd3);
      check_q();
      tick();
      expect_rd("cdb_stored", 0, 32'hDEAD_BEEF, 1'b0, 4'd3);
      check_q();

      // collision: CDB tag3 and re-dispatch r5 tag9 in the same cycle
      disp(5, 3);
      tick();
      cdb(3, 32'h11);
      disp(5, 9);
      expect_rd("coll_same", 0, 32'h11, 1'b0, 4'd3);
      check_q();
      tick();
      expect_rd("coll_next", 0, 32'h11, 1'b1, 4'd9);
      check_q();
      cdb(3, 32'h99);
      expect_rd("stale_cdb_same", 0, 32'h11, 1'b1, 4'd9);
      check_q();
      tick();
      expect_rd("stale_cdb_next", 0, 32'h11, 1'b1, 4'd9);
      check_q();
      cdb(9, 32'h22);
      expect_rd("new_cdb_bypass", 0, 32'h22, 1'b0, 4'd9);
      check_q();
      tick();
      expect_rd("new_cdb_stored", 0, 32'h22, 1'b0, 4'd9);
      check_q();

      // asynchronous reset mid-traffic with r5 busy, checked without a clock edge
      disp(5, 6);
      tick();
      disp(6, 2);
      cdb(1, 32'h1);
      #2 rst_in = 1'b0;
      expect_rd("async_rst_p0", 0, '0, 1'b0, '0);
      expect_rd("async_rst_p1", 1, '0, 1'b0, '0);
      check_q();
      #1 rst_in = 1'b1;
      idle();
      expect_rd("post_rst", 0, '0, 1'b0, '0);
      check_q();
      tick();

      // flush: r2 gets an old value, then r1/r2 busy
      disp(2, 2);
      tick();
      cdb(2, 32'h77);
      tick();
      disp(1, 1);
      tick();
      disp(2, 2);
      tick();
      bus.flush_in = 1'b1;
      cdb(1, 32'h55);
      disp(3, 4);
      set_rs(0, 1); set_rs(1, 2); set_rs(2, 3);
      expect_rd("flush_r1_same", 0, 32'h55, 1'b0, 4'd1);
      expect_rd("flush_r2_same", 1, 32'h77, 1'b1, 4'd2);
      expect_rd("flush_r3_same", 2, '0, 1'b0, '0);
      check_q();
      tick();
      expect_rd("flush_r1_next", 0, 32'h55, 1'b0, 4'd1);
      expect_rd("flush_r2_next", 1, 32'h77, 1'b0, 4'd2);
      expect_rd("flush_r3_next", 2, '0, 1'b0, '0);
      check_q();
      cdb(2, 32'h99);
      tick();
      expect_rd("post_flush_cdb", 1, 32'h77, 1'b0, 4'd2);
      check_q();

      // register 0 is immutable
      for (int k = 0; k < 4; k++) set_rs(k, 0);
      disp(0, 5);
      tick();
      cdb(5, 32'hFF);
      disp(0, 5);
      for (int k = 0; k < 4; k++) expect_rd("r0_same", k, '0, 1'b0, '0);
      check_q();
      tick();
      for (int k = 0; k < 4; k++) expect_rd("r0_next", k, '0, 1'b0, '0);
      check_q();

      // dispatch and CDB on different registers in the same cycle
      disp(8, 8);
      tick();
      disp(9, 9);
      cdb(8, 32'hAB);
      tick();
      set_rs(0, 8); set_rs(1, 9);
      expect_rd("diff_reg_cdb", 0, 32'hAB, 1'b0, 4'd8);
      expect_rd("diff_reg_disp", 1, '0, 1'b1, 4'd9);
      check_q();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Parametrised architectural register file with per-register rename status (busy bit + producer tag) for the Tomasulo-style out-of-order core.
- Sits between decode/dispatch and the reservation stations.
- Dispatch claims a destination register with a tag; a common-data-bus (CDB) broadcast writes the value back and releases the register.
- NREAD combinational read ports return value, busy and tag, with same-cycle CDB bypass.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; must be a power of two ≥ 2
NREAD, 2, number of read ports
TAGW, 4, width of producer tag (reservation-station/ROB id)
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  asynchronous, active-low reset
rs_in  input  NREAD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_val_out  output  NREAD*XLEN  read values, port k at [k*XLEN +: XLEN]
rd_busy_out  output  NREAD  1 = value pending; use rd_tag_out
rd_tag_out  output  NREAD*TAGW  producer tag, port k at [k*TAGW +: TAGW]
disp_valid_in  input  1  dispatch claims disp_rd_in this cycle
disp_rd_in  input  AW  destination register being renamed
disp_tag_in  input  TAGW  tag of new producer
cdb_valid_in  input  1  CDB broadcast valid
cdb_tag_in  input  TAGW  tag of completing producer
cdb_data_in  input  XLEN  result value
flush_in  input  1  mispredict/exception: discard all pending renames

Behaviour:
- State per register i: val[i] (XLEN), busy[i], tag[i] (TAGW).
- Reset (rst_in low, asynchronous, any time including mid-operation): all val, busy and tag clear to 0.
  - Read outputs are combinational, so all return 0/0/0 while in or after reset.
  - Reset overrides every other input.
- Register 0:
  - val=0, busy=0 and tag=0 permanently.
  - Dispatch to rd 0 is ignored.
  - CDB never writes it.
  - Reads of rs 0 return 0, not busy.
- CDB update, when cdb_valid_in is high, for every i≠0 with busy[i]=1 and tag[i]==cdb_tag_in:
  - val[i] <= cdb_data_in; busy[i] <= 0.
  - Registers that are not busy, or that hold a different tag, are untouched (stale/superseded broadcasts are dropped).
- Dispatch, when disp_valid_in is high and disp_rd_in≠0:
  - busy[disp_rd_in] <= 1; tag[disp_rd_in] <= disp_tag_in.
  - val is unchanged.
- Simultaneous dispatch and CDB hitting the same register:
  - The CDB value is written to val.
  - busy stays 1, and tag takes disp_tag_in (newest producer wins).
- Simultaneous dispatch and CDB on different registers: both take effect.
- Flush, when flush_in is high:
  - All busy bits clear at the edge; tags are left as-is but are ignored while not busy.
  - A CDB hit in the same cycle still writes val.
  - Dispatch in the same cycle is discarded (flush has priority).
- Read port k (combinational, zero latency), for r = rs_in[k]:
  - If busy[r] and cdb_valid_in and tag[r]==cdb_tag_in: val = cdb_data_in, busy = 0, tag = tag[r] (bypass).
  - Otherwise: val[r], busy[r], tag[r].
  - Reads never observe a same-cycle dispatch. An instruction with rs==rd sees the pre-rename mapping; its own dispatch takes effect next cycle.
  - Reads are not affected by same-cycle flush_in (the consumer is flushed as well).
- Multiple read ports may address the same register; each returns identical data.
- A tag that matches no busy register is a legal no-op.

Test Plan:
- Reset: assert rst_in=0 mid-traffic with r5 busy, then release → all ports read val=0, busy=0, tag=0 immediately, without waiting for a clock edge.
- Dispatch r5 with tag 3, then read rs=5 next cycle → busy=1, tag=3, val=0. In the dispatch cycle itself, rs=5 still reads busy=0.
- Completion: with r5 busy/tag 3, CDB tag 3 data 0xDEADBEEF →
  - Same cycle: port reads 0xDEADBEEF with busy=0 (bypass).
  - Next cycle: the stored value reads the same.
  - CDB tag 7 in a separate run leaves r5 busy.
- Collision: r5 busy/tag 3; in one cycle, CDB tag 3 data 0x11 plus dispatch r5 tag 9 → next cycle r5 val=0x11, busy=1, tag=9. A later CDB tag 3 is ignored; CDB tag 9 data 0x22 → val=0x22, busy=0.
- Flush: r1 tag 1 and r2 tag 2 busy; flush_in with CDB tag 1 data 0x55 and dispatch r3 tag 4 → r1=0x55, r2 not busy with old val, r3 not busy.
- Register 0: dispatch rd=0 tag 5 and CDB tag 5 data 0xFF; NREAD=4 build with all ports on rs=0 → all read val=0, busy=0, tag=0.
